// File: rtl/uart_rx_os_pkg.sv
// Shared UART definitions: parity modes, receiver state encodings and the
// baud divider calculation. The transmitter uses the same package.
package uart_rx_os_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // Receiver FSM encodings, kept as plain 3-bit constants for compatibility
  // with older blocks that compare against them directly.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // System clocks per oversample tick, truncated.
  function automatic int unsigned calc_divider(input int unsigned freq,
                                               input int unsigned speed,
                                               input int unsigned oversample);
    return freq / (speed * oversample);
  endfunction

  // Two-out-of-three vote used for mid-bit sampling.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_os_baud_tick.sv
// Oversample tick generator: counts 0..DIVIDER-1 and pulses tick on the last
// count. Holding clear parks the counter at 0 so a new frame starts phase-aligned.
module uart_rx_os_baud_tick
  import uart_rx_os_pkg::*;
#(
  parameter int unsigned DIVIDER = 1
) (
  input  logic CLK_i,
  input  logic Reset_i,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

  logic [CW-1:0] cnt;

  // Divider counter, wrapping on the last count.
  always_ff @(posedge CLK_i or posedge Reset_i) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of block ordering in the simulator.
    if (Reset_i) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = ~clear & (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority-vote bit sampling, false-start
// rejection, parity/framing/overrun reporting and a valid/ready output register.
module uart_rx_os
  import uart_rx_os_pkg::*;
#(
  parameter int unsigned FREQUENCY  = 32'd50_000_000,
  parameter int unsigned SPEED      = 32'd9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 CLK_i,
  input  logic                 Reset_i,
  input  logic                 Rx_i,
  input  logic                 data_ready_i,
  output logic                 data_valid_o,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o
);

  localparam int unsigned DIVIDER = calc_divider(FREQUENCY, SPEED, OVERSAMPLE);
  localparam int unsigned M       = OVERSAMPLE / 2;
  localparam int unsigned OW      = $clog2(OVERSAMPLE);

  localparam logic [OW-1:0] OS_S0   = OW'(M - 1);
  localparam logic [OW-1:0] OS_S1   = OW'(M);
  localparam logic [OW-1:0] OS_DEC  = OW'(M + 1);
  localparam logic [OW-1:0] OS_LAST = OW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST  = 4'(STOP_BITS - 1);
  localparam logic          PARITY_ON  = (PARITY != PARITY_NONE);
  localparam logic          PARITY_REQ = (PARITY == PARITY_ODD);

  logic                 rx_meta, rx_sync, rx_prev;
  logic [2:0]           state;
  logic [OW-1:0]        os_cnt;
  logic [3:0]           bit_cnt;
  logic                 s0, s1, maj;
  logic [DATA_BITS-1:0] shift;
  logic                 parity_err, frame_err;
  logic                 tick, at_dec, at_end, commit;

  // Line synchronizer plus one delayed copy for start-edge detection. The
  // edge requirement keeps a held-low line (break) from restarting frames.
  always_ff @(posedge CLK_i or posedge Reset_i) begin
    if (Reset_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= Rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  uart_rx_os_baud_tick #(
    .DIVIDER (DIVIDER)
  ) u_tick (
    .CLK_i   (CLK_i),
    .Reset_i (Reset_i),
    .clear   (state == ST_IDLE),
    .tick    (tick)
  );

  assign maj = majority3(s0, s1, rx_sync);

  // Per-bit strobes: decision point, end of bit, and frame commit.
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    at_dec = 1'b0;
    at_end = 1'b0;
    if (tick) begin
      at_dec = (os_cnt == OS_DEC);
      at_end = (os_cnt == OS_LAST);
    end
    commit = at_dec && (state == ST_STOP) && (bit_cnt == STOP_LAST);
  end

  // Frame FSM: oversample counting, vote samples, shifting and error capture.
  always_ff @(posedge CLK_i or posedge Reset_i) begin
    if (Reset_i) begin
      state      <= ST_IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      shift      <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (tick) begin
        if (os_cnt == OS_S0) s0 <= rx_sync;
        if (os_cnt == OS_S1) s1 <= rx_sync;
        os_cnt <= at_end ? '0 : os_cnt + OW'(1);
      end
      case (state)
        ST_IDLE: begin
          os_cnt  <= '0;
          bit_cnt <= '0;
          if (rx_prev && !rx_sync) begin
            state      <= ST_START;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
          end
        end
        ST_START: begin
          if (at_dec && maj) begin
            state <= ST_IDLE;               // glitch, not a start bit
          end else if (at_end) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (at_dec) shift <= {maj, shift[DATA_BITS-1:1]};
          if (at_end) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= PARITY_ON ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (at_dec) parity_err <= (((^shift) ^ maj) != PARITY_REQ);
          if (at_end) state <= ST_STOP;
        end
        ST_STOP: begin
          if (at_dec && !maj) frame_err <= 1'b1;
          if (commit) begin
            state <= ST_IDLE;               // resync on the next start edge
          end else if (at_end) begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output register: load on commit, drop valid once the consumer takes it.
  always_ff @(posedge CLK_i or posedge Reset_i) begin
    if (Reset_i) begin
      data_valid_o <= 1'b0;
      data_o       <= '0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else if (commit) begin
      data_valid_o <= 1'b1;
      data_o       <= shift;
      parity_err_o <= parity_err;
      frame_err_o  <= frame_err | ~maj;
      overrun_o    <= data_valid_o & ~data_ready_i;
    end else if (data_valid_o && data_ready_i) begin
      data_valid_o <= 1'b0;
    end
  end

endmodule
